// File: rtl/bcd_counter.sv
// -----------------------------------------------------------------------------
// bcd_counter
//
// Multi-digit up/down BCD counter with synchronous clear, validated
// synchronous load, and selectable wrap or saturate behaviour at the limits.
//
// Parameters
//   DIGITS : number of BCD digits (1..8)
//   WRAP   : 1 = roll over at all-9 / all-0, 0 = saturate at those limits
//
// Ports
//   clk        in   rising-edge clock for all state
//   reset      in   asynchronous, active-high reset (count/carry/load_err -> 0)
//   clear      in   synchronous clear to zero (highest priority)
//   load       in   synchronous load of load_value (second priority)
//   load_value in   BCD value, digit k at [4k+3:4k], digit 0 least significant
//   en         in   count enable, one decimal step per enabled cycle
//   up         in   direction, 1 = increment, 0 = decrement
//   count      out  registered BCD count
//   carry      out  registered one-cycle pulse when a step is attempted at a
//                   limit (all-9 going up, all-0 going down), in either mode
//   at_max     out  count register is all 9s
//   at_zero    out  count register is all 0s
//   load_err   out  registered one-cycle pulse when a load is rejected
//                   because some digit of load_value is 10..15
//
// Control interface: there is no valid/ready handshake. clear, load and en
// are level-sampled on every rising clk edge; at most one action is taken
// per edge with priority clear > load > en, and all results (count, carry,
// load_err) appear one edge later. at_max/at_zero are decoded from the count
// register only, so no output depends combinationally on any input.
// -----------------------------------------------------------------------------
module bcd_counter #(
  parameter int DIGITS = 3,
  parameter int WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  en,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic                  at_max,
  output logic                  at_zero,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  // Registered state
  logic [W-1:0] count_q;
  logic         carry_q;
  logic         load_err_q;

  // Next-state and decode signals
  logic [W-1:0] count_d;
  logic         carry_d;
  logic         load_err_d;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         is_max;
  logic         is_zero;
  logic         load_ok;
  logic         inc_ripple;
  logic         dec_ripple;

  // ---------------------------------------------------------------------------
  // Limit decode of the count register and BCD validity of the load value.
  // ---------------------------------------------------------------------------
  always_comb begin : digit_decode
    is_max  = 1'b1;
    is_zero = 1'b1;
    load_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (count_q[4*k +: 4] != 4'd9) is_max  = 1'b0;
      if (count_q[4*k +: 4] != 4'd0) is_zero = 1'b0;
      if (load_value[4*k +: 4] > 4'd9) load_ok = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Decimal increment. inc_ripple is true while every lower digit is 9, which
  // is exactly when the current digit must move. A moving 9 becomes 0 and
  // keeps the ripple going; any other digit adds one and stops it. Each digit
  // is handled as its own 4-bit field so nothing overflows into a neighbour.
  // From all-9 this naturally yields all-0.
  // ---------------------------------------------------------------------------
  always_comb begin : inc_chain
    inc_val    = count_q;
    inc_ripple = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (inc_ripple) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          inc_ripple        = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decimal decrement, mirror image of the increment: a moving 0 becomes 9
  // and borrows from the next digit. From all-0 this yields all-9.
  // ---------------------------------------------------------------------------
  always_comb begin : dec_chain
    dec_val    = count_q;
    dec_ripple = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (dec_ripple) begin
        if (count_q[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
          dec_ripple        = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Action select: clear > load > en. A rejected load holds the count, so the
  // register can only ever receive zero, a validated load value, or the BCD
  // arithmetic results above.
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    count_d    = count_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok) begin
        count_d = load_value;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (is_max) begin
          // Limit reached: flag it, then either roll over or stay at all-9.
          carry_d = 1'b1;
          count_d = (WRAP != 0) ? inc_val : count_q;
        end else begin
          count_d = inc_val;
        end
      end else begin
        if (is_zero) begin
          carry_d = 1'b1;
          count_d = (WRAP != 0) ? dec_val : count_q;
        end else begin
          count_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign carry    = carry_q;
  assign load_err = load_err_q;
  assign at_max   = is_max;
  assign at_zero  = is_zero;

endmodule

// File: tb/tb_bcd_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter
//
// Four counters share clock, reset and the control lines:
//   u_w  DIGITS=3 WRAP=1   directed wrap / borrow / priority / reset steps
//   u_s  DIGITS=3 WRAP=0   directed saturation steps
//   u_d1 DIGITS=1 WRAP=1   random sweep against a decimal integer model
//   u_d8 DIGITS=8 WRAP=1   random sweep against a decimal integer model
// Only the instance under test in each step is checked.
// -----------------------------------------------------------------------------
module tb_bcd_counter;

  // ---------------------------------------------------------------- clock/reset
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- stimulus
  logic        clear;
  logic        load;
  logic        en;
  logic        up;
  logic [11:0] lv3;
  logic [3:0]  lv1;
  logic [31:0] lv8;

  logic [11:0] w_count, s_count;
  logic        w_carry, w_at_max, w_at_zero, w_load_err;
  logic        s_carry, s_at_max, s_at_zero, s_load_err;
  logic [3:0]  d1_count;
  logic        d1_carry, d1_at_max, d1_at_zero, d1_load_err;
  logic [31:0] d8_count;
  logic        d8_carry, d8_at_max, d8_at_zero, d8_load_err;

  bcd_counter #(.DIGITS(3), .WRAP(1)) u_w (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv3),
    .en(en), .up(up), .count(w_count), .carry(w_carry), .at_max(w_at_max),
    .at_zero(w_at_zero), .load_err(w_load_err)
  );

  bcd_counter #(.DIGITS(3), .WRAP(0)) u_s (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv3),
    .en(en), .up(up), .count(s_count), .carry(s_carry), .at_max(s_at_max),
    .at_zero(s_at_zero), .load_err(s_load_err)
  );

  bcd_counter #(.DIGITS(1), .WRAP(1)) u_d1 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv1),
    .en(en), .up(up), .count(d1_count), .carry(d1_carry), .at_max(d1_at_max),
    .at_zero(d1_at_zero), .load_err(d1_load_err)
  );

  bcd_counter #(.DIGITS(8), .WRAP(1)) u_d8 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(lv8),
    .en(en), .up(up), .count(d8_count), .carry(d8_carry), .at_max(d8_at_max),
    .at_zero(d8_at_zero), .load_err(d8_load_err)
  );

  // ---------------------------------------------------------------- scoreboard
  int          checks;
  int          failures;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [31:0] x, input int n);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < n; k++)
      if (x[4*k +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Decimal reference for a WRAP=1 counter held as a plain integer.
  task automatic model_step(input int unsigned v, input int unsigned vmax,
                            input logic c, input logic l, input logic bad,
                            input int unsigned ld, input logic e, input logic u,
                            output int unsigned nv, output logic cy, output logic er);
    nv = v;
    cy = 1'b0;
    er = 1'b0;
    if (c) begin
      nv = 0;
    end else if (l) begin
      if (bad) er = 1'b1;
      else     nv = ld;
    end else if (e) begin
      if (u) begin
        if (v == vmax) begin nv = 0; cy = 1'b1; end
        else nv = v + 1;
      end else begin
        if (v == 0) begin nv = vmax; cy = 1'b1; end
        else nv = v - 1;
      end
    end
  endtask

  // ---------------------------------------------------------------- sweep state
  int unsigned v1, v8, ld1, ld8, nv1, nv8;
  logic        bad1, bad8, cy1, cy8, er1, er8;
  logic [31:0] tmp;
  int          r;
  int          kk;

  // ---------------------------------------------------------------- sequence
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    lv3      = '0;
    lv1      = '0;
    lv8      = '0;

    // Reset asserted before any clock edge must act immediately.
    #1 reset = 1'b1;
    #2;
    chk("rst_count",    32'(w_count), 32'h0);
    chk("rst_carry",    32'(w_carry), 32'h0);
    chk("rst_load_err", 32'(w_load_err), 32'h0);
    chk("rst_at_zero",  32'(w_at_zero), 32'h1);
    chk("rst_at_max",   32'(w_at_max), 32'h0);
    tick();
    reset = 1'b0;

    // Increment with carry between digits.
    load = 1'b1; lv3 = 12'h259; tick();
    chk("ld_259", 32'(w_count), 32'h259);
    load = 1'b0; en = 1'b1; up = 1'b1; tick();
    chk("inc_260",       32'(w_count), 32'h260);
    chk("inc_260_carry", 32'(w_carry), 32'h0);
    tick();
    chk("inc_261",       32'(w_count), 32'h261);
    chk("inc_261_carry", 32'(w_carry), 32'h0);

    // Increment wrap from all-9.
    en = 1'b0; load = 1'b1; lv3 = 12'h999; tick();
    chk("ld_999_max", 32'(w_at_max), 32'h1);
    load = 1'b0; en = 1'b1; up = 1'b1; tick();
    chk("wrap_up_count",  32'(w_count), 32'h000);
    chk("wrap_up_carry",  32'(w_carry), 32'h1);
    chk("wrap_up_zero",   32'(w_at_zero), 32'h1);
    en = 1'b0; tick();
    chk("wrap_up_carry_drop", 32'(w_carry), 32'h0);
    chk("hold_count",         32'(w_count), 32'h000);

    // Decrement with borrow, then decrement wrap from all-0.
    load = 1'b1; lv3 = 12'h100; tick();
    load = 1'b0; en = 1'b1; up = 1'b0; tick();
    chk("dec_099",       32'(w_count), 32'h099);
    chk("dec_099_carry", 32'(w_carry), 32'h0);
    en = 1'b0; load = 1'b1; lv3 = 12'h000; tick();
    load = 1'b0; en = 1'b1; up = 1'b0; tick();
    chk("wrap_dn_count", 32'(w_count), 32'h999);
    chk("wrap_dn_carry", 32'(w_carry), 32'h1);
    chk("wrap_dn_max",   32'(w_at_max), 32'h1);
    en = 1'b0; tick();
    chk("wrap_dn_carry_drop", 32'(w_carry), 32'h0);

    // Saturation (WRAP=0 instance).
    load = 1'b1; lv3 = 12'h998; tick();
    chk("sat_ld_998", 32'(s_count), 32'h998);
    load = 1'b0; en = 1'b1; up = 1'b1; tick();
    chk("sat1_count", 32'(s_count), 32'h999);
    chk("sat1_carry", 32'(s_carry), 32'h0);
    chk("sat1_max",   32'(s_at_max), 32'h1);
    tick();
    chk("sat2_count", 32'(s_count), 32'h999);
    chk("sat2_carry", 32'(s_carry), 32'h1);
    chk("sat2_max",   32'(s_at_max), 32'h1);
    tick();
    chk("sat3_count", 32'(s_count), 32'h999);
    chk("sat3_carry", 32'(s_carry), 32'h1);
    chk("sat3_max",   32'(s_at_max), 32'h1);
    en = 1'b0; load = 1'b1; lv3 = 12'h000; tick();
    chk("sat_ld_carry", 32'(s_carry), 32'h0);
    load = 1'b0; en = 1'b1; up = 1'b0; tick();
    chk("sat_dn_count", 32'(s_count), 32'h000);
    chk("sat_dn_carry", 32'(s_carry), 32'h1);
    en = 1'b0;

    // Priority: clear beats load and en.
    load = 1'b1; lv3 = 12'h555; tick();
    clear = 1'b1; load = 1'b1; lv3 = 12'h123; en = 1'b1; up = 1'b1; tick();
    chk("prio_clear_count", 32'(w_count), 32'h000);
    chk("prio_clear_carry", 32'(w_carry), 32'h0);
    // load beats en
    clear = 1'b0; load = 1'b1; lv3 = 12'h321; en = 1'b1; tick();
    chk("prio_load_count", 32'(w_count), 32'h321);
    chk("prio_load_carry", 32'(w_carry), 32'h0);
    // Invalid load holds the count and pulses load_err for one cycle.
    en = 1'b0; load = 1'b1; lv3 = 12'h1A3; tick();
    chk("bad_ld_count", 32'(w_count), 32'h321);
    chk("bad_ld_err",   32'(w_load_err), 32'h1);
    load = 1'b0; tick();
    chk("bad_ld_err_drop", 32'(w_load_err), 32'h0);
    chk("bad_ld_hold",     32'(w_count), 32'h321);

    // Asynchronous reset clears a pending carry without a clock edge.
    load = 1'b1; lv3 = 12'h999; tick();
    load = 1'b0; en = 1'b1; up = 1'b1; tick();
    en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_carry", 32'(w_carry), 32'h0);
    #1 reset = 1'b0;
    // Asynchronous reset clears a pending load_err.
    tick();
    load = 1'b1; lv3 = 12'hF00; tick();
    load = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_load_err", 32'(w_load_err), 32'h0);
    #1 reset = 1'b0;
    tick();

    // Asynchronous reset with count=0x457, then first edge after release.
    load = 1'b1; lv3 = 12'h457; tick();
    chk("ld_457", 32'(w_count), 32'h457);
    load = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_count",   32'(w_count), 32'h000);
    chk("arst_at_zero", 32'(w_at_zero), 32'h1);
    en = 1'b1; up = 1'b1;
    tick();
    chk("arst_hold", 32'(w_count), 32'h000);
    reset = 1'b0;
    tick();
    chk("arst_release", 32'(w_count), 32'h001);
    en = 1'b0;

    // Random sweep of the 1- and 8-digit counters against integer models.
    clear = 1'b1; tick();
    clear = 1'b0;
    v1 = 0;
    v8 = 0;
    for (int i = 0; i < 600; i++) begin
      r     = int'($urandom_range(0, 31));
      clear = (r == 0);
      load  = (r >= 1 && r <= 4);
      en    = ($urandom_range(0, 3) != 0);
      up    = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0:       begin ld1 = 0; ld8 = 0; end
        1:       begin ld1 = 9; ld8 = 99999999; end
        2:       begin ld1 = 8; ld8 = 99999998; end
        default: begin ld1 = $urandom_range(0, 9); ld8 = $urandom_range(0, 99999999); end
      endcase
      bad1 = ($urandom_range(0, 3) == 0);
      bad8 = ($urandom_range(0, 3) == 0);
      tmp  = to_bcd(ld1);
      lv1  = tmp[3:0];
      if (bad1) lv1 = 4'($urandom_range(10, 15));
      lv8 = to_bcd(ld8);
      if (bad8) begin
        kk = int'($urandom_range(0, 7));
        lv8[4*kk +: 4] = 4'($urandom_range(10, 15));
      end
      model_step(v1, 9, clear, load, bad1, ld1, en, up, nv1, cy1, er1);
      model_step(v8, 99999999, clear, load, bad8, ld8, en, up, nv8, cy8, er8);
      v1 = nv1;
      v8 = nv8;
      exp_q.push_back(to_bcd(v1));
      exp_q.push_back(to_bcd(v8));
      tick();
      chk("d1_count",    32'(d1_count), exp_q.pop_front() & 32'hF);
      chk("d8_count",    d8_count, exp_q.pop_front());
      chk("d1_carry",    32'(d1_carry), 32'(cy1));
      chk("d8_carry",    32'(d8_carry), 32'(cy8));
      chk("d1_load_err", 32'(d1_load_err), 32'(er1));
      chk("d8_load_err", 32'(d8_load_err), 32'(er8));
      chk("d1_at_max",   32'(d1_at_max), 32'(v1 == 9));
      chk("d8_at_zero",  32'(d8_at_zero), 32'(v8 == 0));
      chk("d1_digits",   32'(digits_ok(32'(d1_count), 1)), 32'h1);
      chk("d8_digits",   32'(digits_ok(d8_count, 8)), 32'h1);
    end
    clear = 1'b0;
    load  = 1'b0;
    en    = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
